// File: rtl/ddr_axi_burst_responder.sv
// AXI4 INCR-burst slave backed by a synchronous word memory; DDR-side endpoint
// for ddr_comm_top in simulation and loopback builds.
// Optional: define DDR_RESP_RAND_STALL_EN for LFSR-driven wready/rvalid stalls.
module ddr_axi_burst_responder #(
    parameter int unsigned DDR_DATA_WIDTH = 16,
    parameter int unsigned MEM_AW         = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic [31:0]                   s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic [2:0]                    s_axi_awprot,
    input  logic [3:0]                    s_axi_awcache,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [DDR_DATA_WIDTH*4-1:0]   s_axi_wdata,
    input  logic [DDR_DATA_WIDTH/2-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [31:0]                   s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic [2:0]                    s_axi_arprot,
    input  logic [3:0]                    s_axi_arcache,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [DDR_DATA_WIDTH*4-1:0]   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int unsigned DW    = DDR_DATA_WIDTH * 4;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned DEPTH = 1 << MEM_AW;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DW-1:0] mem [DEPTH];

    wstate_t           wstate_q, wstate_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, wen_q, wen_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [MEM_AW-1:0] widx_q, widx_d;
    logic [7:0]        wcnt_q, wcnt_d, wlen_q, wlen_d;
    logic              mem_we;

    rstate_t           rstate_q, rstate_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d, rok_q, rok_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [MEM_AW-1:0] ridx_q, ridx_d, p_idx;
    logic [7:0]        rbeat_q, rbeat_d, rlen_q, rlen_d, p_beat, p_len;
    logic              p_ok, present;

    logic              stall;
    logic              aw_hit, aw_fmt_ok, ar_hit, ar_fmt_ok, w_hs, w_final;
    logic              unused_ok;

    assign unused_ok = &{1'b0, s_axi_awaddr[2:0], s_axi_araddr[2:0], s_axi_awprot,
                         s_axi_awcache, s_axi_arprot, s_axi_arcache};

`ifdef DDR_RESP_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Free-running x^16+x^14+x^13+x^11+1 stall source
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR register, reseeded on reset
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) lfsr_q <= 16'hACE1;
        else                lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    assign aw_hit    = s_axi_awaddr[31:MEM_AW+3] == BASE_ADDR[31:MEM_AW+3];
    assign aw_fmt_ok = (s_axi_awburst == 2'b01) && (s_axi_awsize == 3'd3);
    assign ar_hit    = s_axi_araddr[31:MEM_AW+3] == BASE_ADDR[31:MEM_AW+3];
    assign ar_fmt_ok = (s_axi_arburst == 2'b01) && (s_axi_arsize == 3'd3);

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q & ~stall;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;

    assign w_hs    = s_axi_wvalid & s_axi_wready;
    assign w_final = wcnt_q == wlen_q;

    // Write channel next-state: address latch, beat acceptance, response hold
    always_comb begin
        wstate_d = wstate_q;
        wready_d = wready_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        widx_d   = widx_q;
        wcnt_d   = wcnt_q;
        wlen_d   = wlen_q;
        wen_d    = wen_q;
        mem_we   = 1'b0;
        unique case (wstate_q)
            W_IDLE: if (s_axi_awvalid && awready_q) begin
                wstate_d = W_DATA;
                wready_d = 1'b1;
                widx_d   = s_axi_awaddr[MEM_AW+2:3];
                wcnt_d   = '0;
                wlen_d   = s_axi_awlen;
                wen_d    = aw_hit && aw_fmt_ok;
                bresp_d  = !aw_hit ? DECERR : (!aw_fmt_ok ? SLVERR : OKAY);
            end
            W_DATA: if (w_hs) begin
                mem_we = wen_q;
                widx_d = widx_q + MEM_AW'(1);
                wcnt_d = wcnt_q + 8'd1;
                // a wlast error never masks an earlier decode error
                if ((s_axi_wlast != w_final) && (bresp_q == OKAY)) bresp_d = SLVERR;
                if (w_final) begin
                    wstate_d = W_RESP;
                    wready_d = 1'b0;
                    bvalid_d = 1'b1;
                end
            end
            W_RESP: if (s_axi_bready) begin
                wstate_d = W_IDLE;
                bvalid_d = 1'b0;
            end
            default: wstate_d = W_IDLE;
        endcase
        awready_d = (wstate_d == W_IDLE);
    end

    // Read channel next-state; one beat is loaded from the latched index per present
    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        ridx_d   = ridx_q;
        rbeat_d  = rbeat_q;
        rlen_d   = rlen_q;
        rok_d    = rok_q;
        p_idx    = ridx_q;
        p_beat   = rbeat_q;
        p_len    = rlen_q;
        p_ok     = rok_q;
        present  = 1'b0;
        unique case (rstate_q)
            R_IDLE: if (s_axi_arvalid && arready_q) begin
                rstate_d = R_DATA;
                rlen_d   = s_axi_arlen;
                rok_d    = ar_hit && ar_fmt_ok;
                rresp_d  = !ar_hit ? DECERR : (!ar_fmt_ok ? SLVERR : OKAY);
                ridx_d   = s_axi_araddr[MEM_AW+2:3];
                rbeat_d  = '0;
                // first beat comes straight from the AR fields, not the latches
                p_idx    = s_axi_araddr[MEM_AW+2:3];
                p_beat   = '0;
                p_len    = s_axi_arlen;
                p_ok     = ar_hit && ar_fmt_ok;
                present  = !stall;
            end
            R_DATA: begin
                if (rvalid_q && s_axi_rready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        rstate_d = R_IDLE;
                        rlast_d  = 1'b0;
                    end else begin
                        present = !stall;
                    end
                end else if (!rvalid_q) begin
                    present = !stall;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        if (present) begin
            rvalid_d = 1'b1;
            rdata_d  = p_ok ? mem[p_idx] : '0;
            rlast_d  = (p_beat == p_len);
            ridx_d   = p_idx + MEM_AW'(1);
            rbeat_d  = p_beat + 8'd1;
        end
        arready_d = (rstate_d == R_IDLE);
    end

    // Channel state registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            widx_q    <= '0;
            wcnt_q    <= '0;
            wlen_q    <= '0;
            wen_q     <= 1'b0;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            ridx_q    <= '0;
            rbeat_q   <= '0;
            rlen_q    <= '0;
            rok_q     <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            widx_q    <= widx_d;
            wcnt_q    <= wcnt_d;
            wlen_q    <= wlen_d;
            wen_q     <= wen_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            ridx_q    <= ridx_d;
            rbeat_q   <= rbeat_d;
            rlen_q    <= rlen_d;
            rok_q     <= rok_d;
        end
    end

    // Byte-enabled memory write; a same-cycle read sees the old word
    always_ff @(posedge s_axi_aclk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < SW; b++) begin
                if (s_axi_wstrb[b]) mem[widx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

endmodule
